// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: state codes,
// opcodes, ALU operations and instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam int OPC_W      = 4;
    localparam int REG_ADDR_W = 3;
    localparam int IMM_W      = 6;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h4;
    localparam logic [OPC_W-1:0] OP_LW   = 4'h5;
    localparam logic [OPC_W-1:0] OP_SW   = 4'h6;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'h7;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 2;
    localparam int RT_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
        return (op <= OP_BEQ) || (op == OP_HALT);
    endfunction

    function automatic logic opcode_rtype(input logic [OPC_W-1:0] op);
        return op <= OP_OR;
    endfunction

    function automatic logic [2:0] rtype_alu_op(input logic [OPC_W-1:0] op);
        logic [2:0] alu;
        case (op)
            OP_SUB:  alu = ALU_SUB;
            OP_AND:  alu = ALU_AND;
            OP_OR:   alu = ALU_OR;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Bus bundle between the control unit and the datapath/memory side.
// The control unit is the master: it consumes status and drives controls.
interface cpu_ctrl_fsm_if
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ALU_OP_W = 3
);
    logic                  start;
    logic [DATA_W-1:0]     instr;
    logic                  zero;
    logic                  mem_ready;

    logic                  mem_req;
    logic                  mem_we;
    logic                  mem_addr_sel;
    logic                  ir_load;
    logic                  pc_inc;
    logic                  pc_load;
    logic                  src_sel;
    logic [DATA_W-1:0]     imm;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  rf_we;
    logic                  wb_sel;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  halted;
    logic                  illegal;
    logic [2:0]            state;

    modport master (
        input  start, instr, zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
               src_sel, imm, alu_op, rf_we, wb_sel, rd, rs, rt,
               halted, illegal, state
    );

    modport slave (
        output start, instr, zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
               src_sel, imm, alu_op, rf_we, wb_sel, rd, rs, rt,
               halted, illegal, state
    );
endinterface

// File: rtl/cpu_ctrl_fsm_imm_sext6.sv
// Sign-extends the 6-bit instruction immediate to the datapath width.
module imm_sext6 #(
    parameter int DATA_W = 16
) (
    input  logic [5:0]        i_imm6,
    output logic [DATA_W-1:0] o_imm
);
    assign o_imm = {{(DATA_W-6){i_imm6[5]}}, i_imm6};
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: fetches over a ready-handshaked port, decodes
// the IR and sequences ALU, register-file, PC and memory controls.
//
// state  | meaning
// IDLE   | waiting for start, all controls low
// FETCH  | instruction read from PC, IR/PC update on mem_ready
// DECODE | one quiet cycle, routes halt/illegal opcodes to HALT
// EXEC   | ALU operation; BEQ resolves its branch here
// MEM    | data access at ALU address, held until mem_ready
// WB     | single-cycle register-file write
// HALT   | absorbing until reset
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ALU_OP_W = 3
) (
    input logic            CLK,
    input logic            reset,
    cpu_ctrl_fsm_if.master bus
);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_ir;
    logic                r_illegal;

    logic [OPC_W-1:0]    w_opcode;
    logic                w_legal;
    logic                w_fetch_done;
    logic                w_mem_done;
    logic [DATA_W-1:0]   w_imm;

    logic                w_mem_req;
    logic                w_mem_we;
    logic                w_mem_addr_sel;
    logic                w_ir_load;
    logic                w_pc_inc;
    logic                w_pc_load;
    logic                w_src_sel;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic                w_rf_we;
    logic                w_wb_sel;

    assign w_opcode     = r_ir[OPC_MSB:OPC_LSB];
    assign w_legal      = opcode_legal(w_opcode);
    assign w_fetch_done = (r_state == FETCH) && bus.mem_ready;
    assign w_mem_done   = (r_state == MEM) && bus.mem_ready;

    imm_sext6 #(.DATA_W(DATA_W)) u_imm_sext6 (
        .i_imm6 (r_ir[IMM_MSB:IMM_LSB]),
        .o_imm  (w_imm)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_fetch_done) begin
                r_ir <= bus.instr;
            end
            if ((r_state == DECODE) && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                if (!w_legal || (w_opcode == OP_HALT)) begin
                    w_next_state = HALT;
                end else begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                if (opcode_rtype(w_opcode) || (w_opcode == OP_ADDI)) begin
                    w_next_state = WB;
                end else if ((w_opcode == OP_LW) || (w_opcode == OP_SW)) begin
                    w_next_state = MEM;
                end else if (w_opcode == OP_BEQ) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = HALT;
                end
            end
            MEM: begin
                if (bus.mem_ready) begin
                    w_next_state = (w_opcode == OP_LW) ? WB : FETCH;
                end
            end
            WB:      w_next_state = FETCH;
            HALT:    w_next_state = HALT;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_load      = 1'b0;
        w_pc_inc       = 1'b0;
        w_pc_load      = 1'b0;
        w_src_sel      = 1'b0;
        w_alu_op       = ALU_OP_W'(ALU_ADD);
        w_rf_we        = 1'b0;
        w_wb_sel       = 1'b0;
        case (r_state)
            FETCH: begin
                w_mem_req = 1'b1;
                w_ir_load = w_fetch_done;
                w_pc_inc  = w_fetch_done;
            end
            EXEC: begin
                if (opcode_rtype(w_opcode)) begin
                    w_alu_op = ALU_OP_W'(rtype_alu_op(w_opcode));
                end else if (w_opcode == OP_BEQ) begin
                    // Branch offset is relative to the PC already bumped in FETCH
                    w_alu_op  = ALU_OP_W'(ALU_SUB);
                    w_pc_load = bus.zero;
                end else begin
                    w_src_sel = 1'b1;
                end
            end
            MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (w_opcode == OP_SW);
            end
            WB: begin
                w_rf_we  = 1'b1;
                w_wb_sel = (w_opcode == OP_LW);
            end
            default: ;
        endcase
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr_sel = w_mem_addr_sel;
    assign bus.ir_load      = w_ir_load;
    assign bus.pc_inc       = w_pc_inc;
    assign bus.pc_load      = w_pc_load;
    assign bus.src_sel      = w_src_sel;
    assign bus.alu_op       = w_alu_op;
    assign bus.rf_we        = w_rf_we;
    assign bus.wb_sel       = w_wb_sel;
    assign bus.imm          = w_imm;
    assign bus.rd           = r_ir[RD_MSB:RD_LSB];
    assign bus.rs           = r_ir[RS_MSB:RS_LSB];
    assign bus.rt           = r_ir[RT_MSB:RT_LSB];
    assign bus.halted       = (r_state == HALT);
    assign bus.illegal      = r_illegal;
    assign bus.state        = r_state;

    logic w_unused_done;
    assign w_unused_done = w_mem_done;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: random instruction stream with
// random memory wait states, plus directed reset/halt/illegal scenarios.
module tb_cpu_ctrl_fsm;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    cpu_ctrl_fsm_if #(.DATA_W(16), .ALU_OP_W(3)) bus ();

    cpu_ctrl_fsm #(.DATA_W(16), .ALU_OP_W(3)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [41:0] w_all;
    assign w_all = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_load,
                    bus.pc_inc, bus.pc_load, bus.src_sel, bus.imm, bus.alu_op,
                    bus.rf_we, bus.wb_sel, bus.rd, bus.rs, bus.rt,
                    bus.halted, bus.illegal, bus.state};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expects to be entered at a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic z);
        logic [3:0]  op;
        logic [2:0]  q[$];
        logic [2:0]  exp_end;
        logic [15:0] exp_imm;
        logic [2:0]  prev_mem;
        logic        is_r, is_addi, is_lw, is_sw, is_beq, is_stop, writes_rf;
        logic        wb_seen, rd_seen;
        logic [2:0]  rd_obs;
        int fetch_i, mem_i;
        int n_inc, n_load, n_ir, n_rf, n_we, n_req, viol;

        op        = ins[15:12];
        is_r      = (op <= 4'h3);
        is_addi   = (op == 4'h4);
        is_lw     = (op == 4'h5);
        is_sw     = (op == 4'h6);
        is_beq    = (op == 4'h7);
        is_stop   = (op > 4'h7);
        writes_rf = is_r || is_addi || is_lw;
        exp_imm   = {{10{ins[5]}}, ins[5:0]};

        repeat (fw + 1) q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        if (!is_stop) begin
            q.push_back(S_EXEC);
            if (is_lw || is_sw) repeat (mw + 1) q.push_back(S_MEM);
            if (writes_rf) q.push_back(S_WB);
        end
        exp_end = is_stop ? S_HALT : S_FETCH;

        fetch_i = 0; mem_i = 0;
        n_inc = 0; n_load = 0; n_ir = 0; n_rf = 0; n_we = 0; n_req = 0; viol = 0;
        wb_seen = 1'b0; rd_seen = 1'b0; rd_obs = '0; prev_mem = '0;

        for (int i = 0; i < q.size(); i++) begin
            bus.instr = ins;
            bus.zero  = z;
            bus.start = 1'($urandom_range(0, 1));
            if (q[i] == S_FETCH) begin
                bus.mem_ready = (fetch_i == fw);
                fetch_i++;
            end else if (q[i] == S_MEM) begin
                bus.mem_ready = (mem_i == mw);
                mem_i++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            chk("state_seq", 64'(bus.state), 64'(q[i]));
            n_inc  += int'(bus.pc_inc);
            n_load += int'(bus.pc_load);
            n_ir   += int'(bus.ir_load);
            n_rf   += int'(bus.rf_we);
            n_we   += int'(bus.mem_we);
            n_req  += int'(bus.mem_req);
            if (bus.pc_inc && bus.pc_load) viol++;
            if (bus.rf_we && bus.mem_req) viol++;
            if (bus.mem_we && !bus.mem_addr_sel) viol++;
            if (i > 0 && q[i] == q[i-1] &&
                {bus.mem_req, bus.mem_we, bus.mem_addr_sel} != prev_mem) viol++;
            prev_mem = {bus.mem_req, bus.mem_we, bus.mem_addr_sel};
            if (q[i] == S_EXEC) begin
                chk("exec_src_sel", 64'(bus.src_sel), 64'(is_addi || is_lw || is_sw));
                chk("exec_alu_op", 64'(bus.alu_op), is_r ? 64'(op[1:0]) : (is_beq ? 64'd1 : 64'd0));
                chk("exec_imm", 64'(bus.imm), 64'(exp_imm));
                chk("exec_rs", 64'(bus.rs), 64'(ins[8:6]));
                chk("exec_rt", 64'(bus.rt), 64'(ins[2:0]));
            end
            if (bus.rf_we) begin
                wb_seen = bus.wb_sel;
                rd_seen = 1'b1;
                rd_obs  = bus.rd;
            end
            @(negedge CLK);
        end

        bus.mem_ready = 1'b0;
        #1;
        chk("end_state", 64'(bus.state), 64'(exp_end));
        chk("pc_inc_count", 64'(n_inc), 64'd1);
        chk("ir_load_count", 64'(n_ir), 64'd1);
        chk("pc_load_count", 64'(n_load), 64'(is_beq && z));
        chk("rf_we_count", 64'(n_rf), 64'(writes_rf));
        chk("mem_we_cycles", 64'(n_we), is_sw ? 64'(mw + 1) : 64'd0);
        chk("mem_req_cycles", 64'(n_req), 64'(fw + 1 + ((is_lw || is_sw) ? mw + 1 : 0)));
        chk("rule_violations", 64'(viol), 64'd0);
        if (rd_seen) begin
            chk("wb_sel", 64'(wb_seen), 64'(is_lw));
            chk("wb_rd", 64'(rd_obs), 64'(ins[11:9]));
        end
        if (is_stop) begin
            chk("halted", 64'(bus.halted), 64'd1);
            chk("illegal_flag", 64'(bus.illegal), 64'(op != 4'hF));
        end
    endtask

    task automatic do_start();
        @(negedge CLK);
        bus.start     = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        chk("start_from_idle", 64'(bus.state), 64'(S_IDLE));
        @(negedge CLK);
    endtask

    task automatic halt_hold(input logic exp_illegal);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            bus.start     = k[0];
            bus.mem_ready = 1'b1;
            #1;
            chk("halt_absorbing", 64'(bus.state), 64'(S_HALT));
            chk("halt_illegal_sticky", 64'(bus.illegal), 64'(exp_illegal));
        end
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("reset_all_zero", 64'(w_all), 64'd0);
        @(negedge CLK);
        bus.start = 1'b0;
        reset     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start     = 1'b0;
        bus.instr     = 16'h4A7F;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #12;
        chk("reset_outputs", 64'(w_all), 64'd0);
        @(negedge CLK);
        reset = 1'b1;

        do_start();
        bus.start = 1'b0;
        #1;
        chk("fetch_state", 64'(bus.state), 64'(S_FETCH));
        chk("fetch_mem_req", 64'(bus.mem_req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midreq_reset_req", 64'(bus.mem_req), 64'd0);
        chk("midreq_reset_state", 64'(bus.state), 64'(S_IDLE));
        chk("midreq_reset_all", 64'(w_all), 64'd0);
        @(negedge CLK);
        reset = 1'b1;

        do_start();
        for (int n = 0; n < 60; n++) begin
            run_instr({4'($urandom_range(0, 7)), 12'($urandom)},
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
            @(negedge CLK);
            #0;
        end

        run_instr(16'h4A7F, 0, 0, 1'b0);
        run_instr(16'h5245, 0, 3, 1'b0);
        run_instr(16'h7003, 0, 0, 1'b1);
        run_instr(16'h7003, 0, 0, 1'b0);
        run_instr(16'h6000, 0, 0, 1'b0);
        run_instr(16'h6000, 1, 2, 1'b1);
        run_instr(16'hF000, 0, 0, 1'b0);
        halt_hold(1'b0);
        async_reset();

        do_start();
        run_instr(16'h9123, 1, 0, 1'b0);
        halt_hold(1'b1);
        async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control unit for the 16-bit CPU datapath. It fetches an instruction over a ready-handshaked memory port, latches and decodes it, and drives the immediate-select mux (`src_sel`), ALU opcode, register-file write, PC update and memory requests through FETCH/DECODE/EXEC/MEM/WB states. It emits the sign-extended 6-bit immediate that feeds the immediate operand path.

## Interface
- `DATA_W`, default 16: instruction and immediate width.
- `ALU_OP_W`, default 3: ALU opcode width.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching; ignored in other states.
- `instr`  in  DATA_W  memory read data; captured as the instruction on FETCH handshake.
- `zero`  in  1  ALU zero flag, valid in EXEC.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write request (SW only).
- `mem_addr_sel`  out  1  address source: 0 = PC, 1 = ALU result.
- `ir_load`  out  1  instruction captured this cycle.
- `pc_inc`  out  1  PC += 1 this cycle.
- `pc_load`  out  1  PC += `imm` this cycle (taken branch).
- `src_sel`  out  1  ALU B operand: 0 = register `rt`, 1 = `imm`.
- `imm`  out  DATA_W  `ir[5:0]` sign-extended.
- `alu_op`  out  ALU_OP_W  encodings: ADD=0, SUB=1, AND=2, OR=3.
- `rf_we`  out  1  register-file write enable.
- `wb_sel`  out  1  write-back source: 0 = ALU, 1 = memory data.
- `rd`, `rs`, `rt`  out  3 each  `ir[11:9]`, `ir[8:6]`, `ir[2:0]`.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set on an undefined opcode.
- `state`  out  3  current state, for debug.

## Operation
- Internal IR register (DATA_W). Opcode is `ir[15:12]`:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: R-type.
  - 4 ADDI, 5 LW, 6 SW, 7 BEQ.
  - F HALT.
  - All other opcodes are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **IDLE:** all controls 0. Moves to FETCH when `start` is high.
- **FETCH:** `mem_req`=1, `mem_addr_sel`=0. Wait while `mem_ready`=0.
  - In the cycle `mem_ready`=1: `ir_load`=1 and `pc_inc`=1 (Mealy), IR <= `instr`, next state DECODE.
- **DECODE:** one cycle, no side effects.
  - HALT opcode -> HALT.
  - Illegal opcode -> HALT and set `illegal`.
  - Otherwise -> EXEC.
- **EXEC:**
  - R-type: `src_sel`=0, `alu_op` taken from the opcode -> WB.
  - ADDI: `src_sel`=1, ADD -> WB.
  - LW/SW: `src_sel`=1, ADD -> MEM.
  - BEQ: `src_sel`=0, SUB. If `zero`=1, `pc_load`=1. Next state FETCH.
- **MEM:** `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(SW). Held stable until `mem_ready`=1.
  - LW -> WB.
  - SW -> FETCH.
- **WB:** `rf_we`=1 for exactly one cycle. `wb_sel`=1 for LW, 0 otherwise. Next state FETCH.
- **HALT:** absorbing. Only `reset` exits it. `start` is ignored.
- `imm`, `rd`, `rs`, `rt` are decoded combinationally from IR and are valid from DECODE onward.
- `pc_inc` and `pc_load` are never both high. `rf_we` and `mem_req` are never both high.

## Timing
- Reset asserted (async): state=IDLE, IR=0, `illegal`=0. Every output is 0, including `imm`, `rd`, `rs`, `rt` and `state`.
- Reset asserted mid-request drops `mem_req` immediately, with no wait for `mem_ready`.
- Reset release is synchronous to `CLK`.
- Cycle counts with zero-wait memory (`mem_ready` tied high):
  - R-type and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
- Each wait cycle on `mem_ready` adds 1 cycle.
- `mem_req`, `mem_we` and `mem_addr_sel` stay constant while waiting.
- `mem_ready` arriving when `mem_req`=0 is ignored.
- `start` held high continuously has no effect after IDLE.
- `pc_load` is Mealy on `zero`. The PC offset assumes PC already incremented in FETCH.

## Structure
- Package `cpu_pkg`:
  - state enum (3-bit): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
  - opcode localparams.
  - ALU op localparams.
  - field bit positions.
- One sub-module `imm_sext6`: 6-to-16 sign extension. This is the same function the immediate mux path relies on.
- The FSM keeps a state register and IR register, plus combinational next-state and output logic.

## Test plan
- Reset low mid-FETCH with `mem_req`=1 -> `mem_req`=0 in the same cycle, `state`=0, all outputs 0.
- `instr`=0x4A7F (ADDI rd=5, rs=1, imm=-1), `mem_ready`=1 -> exactly 4 cycles, with:
  - `src_sel`=1 and `imm`=0xFFFF in EXEC;
  - `rf_we`=1, `rd`=5 and `wb_sel`=0 in WB;
  - one `pc_inc`.
- LW 0x5245 with `mem_ready` low for 3 cycles in MEM -> `mem_req`, `mem_addr_sel`=1 and `mem_we`=0 held stable; then WB with `wb_sel`=1; total 8 cycles.
- BEQ 0x7003 with `zero`=1 -> `pc_load`=1 in EXEC and `rf_we` never high. With `zero`=0 -> `pc_load` stays 0. Both cases take 3 cycles.
- Opcode 0x9xxx -> DECODE goes to HALT with `illegal`=1 and `halted`=1; it stays there despite `start` pulses until `reset`.
- SW 0x6000 -> `mem_we`=1 only in MEM and never in FETCH; returns to FETCH without a WB cycle.
